// File: rtl/pte_ad_updater.sv
// Hardware A/D-bit updater for Sv39 leaf PTEs: sets A (and D on a store) with a
// 64-bit AMO-OR to the PTE address and returns the resulting PTE fields or a fault.
module pte_ad_updater #(
    parameter int PADDR_BITS = 32,
    parameter int PPN_BITS   = 44,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [PADDR_BITS-1:0] io_req_addr,
    input  logic                  io_req_store,
    input  logic [PPN_BITS-1:0]   io_req_ppn,
    input  logic                  io_req_d,
    input  logic                  io_req_a,
    input  logic                  io_req_g,
    input  logic                  io_req_u,
    input  logic                  io_req_x,
    input  logic                  io_req_w,
    input  logic                  io_req_r,
    input  logic                  io_req_v,
    output logic                  io_mem_req_valid,
    input  logic                  io_mem_req_ready,
    output logic [PADDR_BITS-1:0] io_mem_req_addr,
    output logic [63:0]           io_mem_req_data,
    input  logic                  io_mem_resp_valid,
    input  logic                  io_mem_resp_nack,
    input  logic [63:0]           io_mem_resp_data,
    output logic                  io_resp_valid,
    input  logic                  io_resp_ready,
    output logic [PPN_BITS-1:0]   io_resp_ppn,
    output logic                  io_resp_d,
    output logic                  io_resp_a,
    output logic                  io_resp_g,
    output logic                  io_resp_u,
    output logic                  io_resp_x,
    output logic                  io_resp_w,
    output logic                  io_resp_r,
    output logic                  io_resp_v,
    output logic                  io_resp_fault,
    output logic                  io_resp_skipped
);

    localparam int CNT_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, MREQ, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic [PADDR_BITS-1:0] addr_q, addr_d;
    logic                  store_q, store_d;
    logic [PPN_BITS-1:0]   ppn_q, ppn_d;
    logic [7:0]            flags_q, flags_d;
    logic [CNT_W-1:0]      retry_q, retry_d;
    logic                  req_ready_q, req_ready_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [PPN_BITS-1:0]   resp_ppn_q, resp_ppn_d;
    logic [7:0]            resp_flags_q, resp_flags_d;
    logic                  resp_fault_q, resp_fault_d;
    logic                  resp_skipped_q, resp_skipped_d;

    logic [7:0]            req_flags;
    logic                  req_bad;
    logic                  req_done;
    logic [CNT_W-1:0]      retry_inc;
    logic [PPN_BITS-1:0]   old_ppn;
    logic                  old_stale;
    logic                  unused_rsw;

    // Flag byte uses the PTE bit layout: {d,a,g,u,x,w,r,v}
    assign req_flags = {io_req_d, io_req_a, io_req_g, io_req_u,
                        io_req_x, io_req_w, io_req_r, io_req_v};
    assign req_bad   = !io_req_v || (io_req_w && !io_req_r) || (!io_req_r && !io_req_x);
    assign req_done  = io_req_a && (io_req_d || !io_req_store);
    assign retry_inc = retry_q + CNT_W'(1);
    assign old_ppn   = io_mem_resp_data[10 +: PPN_BITS];
    assign old_stale = !io_mem_resp_data[0] || (old_ppn != ppn_q);
    assign unused_rsw = ^{io_mem_resp_data[63:54], io_mem_resp_data[9:8]};

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        store_d         = store_q;
        ppn_d           = ppn_q;
        flags_d         = flags_q;
        retry_d         = retry_q;
        req_ready_d     = req_ready_q;
        mem_req_valid_d = mem_req_valid_q;
        resp_valid_d    = resp_valid_q;
        resp_ppn_d      = resp_ppn_q;
        resp_flags_d    = resp_flags_q;
        resp_fault_d    = resp_fault_q;
        resp_skipped_d  = resp_skipped_q;
        unique case (state_q)
            IDLE: begin
                if (io_req_valid) begin
                    addr_d         = io_req_addr;
                    store_d        = io_req_store;
                    ppn_d          = io_req_ppn;
                    flags_d        = req_flags;
                    retry_d        = '0;
                    req_ready_d    = 1'b0;
                    resp_ppn_d     = io_req_ppn;
                    resp_flags_d   = req_flags;
                    resp_fault_d   = 1'b0;
                    resp_skipped_d = 1'b0;
                    if (req_bad) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                    end else if (req_done) begin
                        state_d        = RESP;
                        resp_valid_d   = 1'b1;
                        resp_skipped_d = 1'b1;
                    end else begin
                        state_d         = MREQ;
                        mem_req_valid_d = 1'b1;
                    end
                end
            end
            MREQ: begin
                if (io_mem_req_ready) begin
                    state_d         = WAIT;
                    mem_req_valid_d = 1'b0;
                end
            end
            WAIT: begin
                if (io_mem_resp_valid) begin
                    if (io_mem_resp_nack) begin
                        retry_d = retry_inc;
                        if (retry_inc == CNT_W'(MAX_RETRY)) begin
                            state_d        = RESP;
                            resp_valid_d   = 1'b1;
                            resp_fault_d   = 1'b1;
                            resp_ppn_d     = ppn_q;
                            resp_flags_d   = flags_q;
                            resp_skipped_d = 1'b0;
                        end else begin
                            state_d         = MREQ;
                            mem_req_valid_d = 1'b1;
                        end
                    end else begin
                        state_d        = RESP;
                        resp_valid_d   = 1'b1;
                        resp_skipped_d = 1'b0;
                        // A cleared V or moved PPN means the PTE was rewritten since the walk
                        if (old_stale) begin
                            resp_fault_d = 1'b1;
                            resp_ppn_d   = ppn_q;
                            resp_flags_d = flags_q;
                        end else begin
                            resp_fault_d = 1'b0;
                            resp_ppn_d   = old_ppn;
                            resp_flags_d = {io_mem_resp_data[7] | store_q, 1'b1,
                                            io_mem_resp_data[5:0]};
                        end
                    end
                end
            end
            RESP: begin
                if (io_resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            store_q         <= 1'b0;
            ppn_q           <= '0;
            flags_q         <= '0;
            retry_q         <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            resp_valid_q    <= 1'b0;
            resp_ppn_q      <= '0;
            resp_flags_q    <= '0;
            resp_fault_q    <= 1'b0;
            resp_skipped_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            store_q         <= store_d;
            ppn_q           <= ppn_d;
            flags_q         <= flags_d;
            retry_q         <= retry_d;
            req_ready_q     <= req_ready_d;
            mem_req_valid_q <= mem_req_valid_d;
            resp_valid_q    <= resp_valid_d;
            resp_ppn_q      <= resp_ppn_d;
            resp_flags_q    <= resp_flags_d;
            resp_fault_q    <= resp_fault_d;
            resp_skipped_q  <= resp_skipped_d;
        end
    end

    assign io_req_ready     = req_ready_q;
    assign io_mem_req_valid = mem_req_valid_q;
    assign io_mem_req_addr  = addr_q & ~PADDR_BITS'(7);
    assign io_mem_req_data  = {56'd0, store_q, 1'b1, 6'd0};
    assign io_resp_valid    = resp_valid_q;
    assign io_resp_ppn      = resp_ppn_q;
    assign io_resp_d        = resp_flags_q[7];
    assign io_resp_a        = resp_flags_q[6];
    assign io_resp_g        = resp_flags_q[5];
    assign io_resp_u        = resp_flags_q[4];
    assign io_resp_x        = resp_flags_q[3];
    assign io_resp_w        = resp_flags_q[2];
    assign io_resp_r        = resp_flags_q[1];
    assign io_resp_v        = resp_flags_q[0];
    assign io_resp_fault    = resp_fault_q;
    assign io_resp_skipped  = resp_skipped_q;

endmodule

// File: tb/tb_pte_ad_updater.sv
// Directed bench for pte_ad_updater: a transaction-level model predicts each
// result and a single negedge process checks the DUT against it.
module tb_pte_ad_updater;

    localparam int MAX_RETRY = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic [31:0] io_req_addr = '0;
    logic        io_req_store = 1'b0;
    logic [43:0] io_req_ppn = '0;
    logic [7:0]  req_fl = '0;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready = 1'b0;
    logic [31:0] io_mem_req_addr;
    logic [63:0] io_mem_req_data;
    logic        io_mem_resp_valid = 1'b0;
    logic        io_mem_resp_nack = 1'b0;
    logic [63:0] io_mem_resp_data = '0;
    logic        io_resp_valid;
    logic        io_resp_ready = 1'b0;
    logic [43:0] io_resp_ppn;
    logic        io_resp_d, io_resp_a, io_resp_g, io_resp_u;
    logic        io_resp_x, io_resp_w, io_resp_r, io_resp_v;
    logic        io_resp_fault, io_resp_skipped;

    always #5 clk = ~clk;

    pte_ad_updater #(.PADDR_BITS(32), .PPN_BITS(44), .MAX_RETRY(MAX_RETRY)) dut (
        .clock(clk), .reset(rst_n),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_addr(io_req_addr), .io_req_store(io_req_store), .io_req_ppn(io_req_ppn),
        .io_req_d(req_fl[7]), .io_req_a(req_fl[6]), .io_req_g(req_fl[5]), .io_req_u(req_fl[4]),
        .io_req_x(req_fl[3]), .io_req_w(req_fl[2]), .io_req_r(req_fl[1]), .io_req_v(req_fl[0]),
        .io_mem_req_valid(io_mem_req_valid), .io_mem_req_ready(io_mem_req_ready),
        .io_mem_req_addr(io_mem_req_addr), .io_mem_req_data(io_mem_req_data),
        .io_mem_resp_valid(io_mem_resp_valid), .io_mem_resp_nack(io_mem_resp_nack),
        .io_mem_resp_data(io_mem_resp_data),
        .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready), .io_resp_ppn(io_resp_ppn),
        .io_resp_d(io_resp_d), .io_resp_a(io_resp_a), .io_resp_g(io_resp_g), .io_resp_u(io_resp_u),
        .io_resp_x(io_resp_x), .io_resp_w(io_resp_w), .io_resp_r(io_resp_r), .io_resp_v(io_resp_v),
        .io_resp_fault(io_resp_fault), .io_resp_skipped(io_resp_skipped)
    );

    // Model expectations for the transaction in flight (written by the driver)
    int          exp_fires = 0;
    logic        exp_fault = 1'b0, exp_skipped = 1'b0, exp_chk = 1'b0;
    logic [43:0] exp_ppn = '0;
    logic [7:0]  exp_flags = '0;
    logic [31:0] exp_maddr = '0;
    logic [63:0] exp_mdata = '0;
    // Hand-computed literal pins for selected transactions
    logic        pin_valid = 1'b0, pin_fields = 1'b0;
    logic        pin_fault = 1'b0, pin_skipped = 1'b0;
    logic [43:0] pin_ppn = '0;
    logic [7:0]  pin_flags = '0;
    int          pin_fires = 0;
    logic [31:0] pin_maddr = '0;
    logic [63:0] pin_mdata = '0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    // Compare process state
    int   cyc = 0, fire_cyc = 0, fires = 0, last_mresp_cyc = 0;
    logic busy = 1'b0, got_mreq = 1'b0, got_resp = 1'b0;
    logic [7:0] dut_flags;
    assign dut_flags = {io_resp_d, io_resp_a, io_resp_g, io_resp_u,
                        io_resp_x, io_resp_w, io_resp_r, io_resp_v};

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_mem_req_valid", {63'd0, io_mem_req_valid}, 64'd0);
            chk("rst_resp_valid", {63'd0, io_resp_valid}, 64'd0);
            chk("rst_req_ready", {63'd0, io_req_ready}, 64'd1);
            busy = 1'b0;
        end else begin
            chk("req_ready", {63'd0, io_req_ready}, {63'd0, !busy});
            if (!busy) begin
                chk("idle_mem_req_valid", {63'd0, io_mem_req_valid}, 64'd0);
                chk("idle_resp_valid", {63'd0, io_resp_valid}, 64'd0);
                if (io_req_valid && io_req_ready) begin
                    busy = 1'b1; fire_cyc = cyc; fires = 0;
                    got_mreq = 1'b0; got_resp = 1'b0; last_mresp_cyc = 0;
                end
            end else begin
                if (io_mem_req_valid) begin
                    chk("mem_req_expected", {63'd0, exp_fires != 0}, 64'd1);
                    if (!got_mreq) begin
                        chk("mem_req_latency", 64'(cyc - fire_cyc), 64'd1);
                        got_mreq = 1'b1;
                    end
                    chk("mem_req_addr", {32'd0, io_mem_req_addr}, {32'd0, exp_maddr});
                    chk("mem_req_data", io_mem_req_data, exp_mdata);
                    if (pin_valid) begin
                        chk("pin_mem_req_addr", {32'd0, io_mem_req_addr}, {32'd0, pin_maddr});
                        chk("pin_mem_req_data", io_mem_req_data, pin_mdata);
                    end
                    if (io_mem_req_ready) fires++;
                end
                if (io_mem_resp_valid) last_mresp_cyc = cyc;
                if (io_resp_valid) begin
                    if (!got_resp) begin
                        chk("resp_latency", 64'(cyc),
                            64'((exp_fires == 0) ? fire_cyc + 1 : last_mresp_cyc + 1));
                        chk("mem_req_fires", 64'(fires), 64'(exp_fires));
                        if (pin_valid) chk("pin_mem_req_fires", 64'(fires), 64'(pin_fires));
                        got_resp = 1'b1;
                    end
                    chk("resp_fault", {63'd0, io_resp_fault}, {63'd0, exp_fault});
                    chk("resp_skipped", {63'd0, io_resp_skipped}, {63'd0, exp_skipped});
                    if (exp_chk) begin
                        chk("resp_ppn", {20'd0, io_resp_ppn}, {20'd0, exp_ppn});
                        chk("resp_flags", {56'd0, dut_flags}, {56'd0, exp_flags});
                    end
                    if (pin_valid) begin
                        chk("pin_resp_fault", {63'd0, io_resp_fault}, {63'd0, pin_fault});
                        chk("pin_resp_skipped", {63'd0, io_resp_skipped}, {63'd0, pin_skipped});
                        if (pin_fields) begin
                            chk("pin_resp_ppn", {20'd0, io_resp_ppn}, {20'd0, pin_ppn});
                            chk("pin_resp_flags", {56'd0, dut_flags}, {56'd0, pin_flags});
                        end
                    end
                    if (io_resp_ready) busy = 1'b0;
                end else if (cyc - fire_cyc > 300) begin
                    chk("resp_timeout", {63'd0, io_resp_valid}, 64'd1);
                    busy = 1'b0;
                end
            end
        end
    end

    // Transaction-level prediction from the PTE rules
    task automatic set_model(input logic [31:0] addr, input logic store, input logic [43:0] ppn,
                             input logic [7:0] fl, input int n_nack, input logic [63:0] old);
        logic v, r, w, x, a, d;
        {d, a, x, w, r, v} = {fl[7], fl[6], fl[3], fl[2], fl[1], fl[0]};
        exp_maddr   = {addr[31:3], 3'b000};
        exp_mdata   = 64'h40 | (store ? 64'h80 : 64'h0);
        exp_skipped = 1'b0;
        exp_ppn     = ppn;
        exp_flags   = fl;
        if (!v || (w && !r) || (!r && !x)) begin
            exp_fires = 0; exp_fault = 1'b1; exp_chk = 1'b0;
        end else if (a && (d || !store)) begin
            exp_fires = 0; exp_fault = 1'b0; exp_skipped = 1'b1; exp_chk = 1'b1;
        end else if (n_nack >= MAX_RETRY) begin
            exp_fires = MAX_RETRY; exp_fault = 1'b1; exp_chk = 1'b1;
        end else begin
            exp_fires = n_nack + 1;
            if (!old[0] || old[53:10] != ppn) begin
                exp_fault = 1'b1; exp_chk = 1'b0;
            end else begin
                exp_fault = 1'b0; exp_chk = 1'b1;
                exp_ppn   = old[53:10];
                exp_flags = old[7:0] | 8'h40 | (store ? 8'h80 : 8'h00);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic store,
                             input logic [43:0] ppn, input logic [7:0] fl);
        int n = 0;
        while (!io_req_ready) begin
            step();
            n++;
            if (n > 100) begin
                $display("FAIL req_ready_wait: req_ready=%0b, required 1", io_req_ready);
                $fatal(1);
            end
        end
        io_req_addr = addr; io_req_store = store; io_req_ppn = ppn; req_fl = fl;
        io_req_valid = 1'b1;
        step();
        io_req_valid = 1'b0;
    endtask

    task automatic mem_serve(input int n_nack, input logic [63:0] old, input int mdelay);
        int nreq = (n_nack >= MAX_RETRY) ? MAX_RETRY : n_nack + 1;
        for (int i = 0; i < nreq; i++) begin
            int n = 0;
            while (!io_mem_req_valid) begin
                step();
                n++;
                if (n > 100) begin
                    $display("FAIL mem_req_wait: mem_req_valid=%0b, required 1", io_mem_req_valid);
                    $fatal(1);
                end
            end
            repeat (mdelay) step();
            io_mem_req_ready = 1'b1;
            step();
            io_mem_req_ready = 1'b0;
            io_mem_resp_valid = 1'b1;
            io_mem_resp_nack = (i < n_nack);
            io_mem_resp_data = old;
            step();
            io_mem_resp_valid = 1'b0;
            io_mem_resp_nack = 1'b0;
        end
    endtask

    task automatic take_resp(input int hold);
        int n = 0;
        while (!io_resp_valid) begin
            step();
            n++;
            if (n > 100) begin
                $display("FAIL resp_wait: resp_valid=%0b, required 1", io_resp_valid);
                $fatal(1);
            end
        end
        repeat (hold) step();
        io_resp_ready = 1'b1;
        step();
        io_resp_ready = 1'b0;
    endtask

    task automatic run(input logic [31:0] addr, input logic store, input logic [43:0] ppn,
                       input logic [7:0] fl, input int n_nack, input logic [63:0] old,
                       input int mdelay, input int hold);
        set_model(addr, store, ppn, fl, n_nack, old);
        drive_req(addr, store, ppn, fl);
        if (exp_fires > 0) mem_serve(n_nack, old, mdelay);
        take_resp(hold);
        pin_valid = 1'b0;
        pin_fields = 1'b0;
    endtask

    task automatic pin_set(input logic fault, input logic skipped, input int nfires,
                           input logic fields, input logic [43:0] ppn, input logic [7:0] fl);
        pin_valid = 1'b1; pin_fault = fault; pin_skipped = skipped; pin_fires = nfires;
        pin_fields = fields; pin_ppn = ppn; pin_flags = fl;
        pin_maddr = 32'h8000_1230; pin_mdata = 64'hC0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #2;
        step();
        rst_n = 1'b1;
        step();

        // Load to an already-accessed PTE: no memory op
        pin_set(1'b0, 1'b1, 0, 1'b1, 44'h12345, 8'h43);
        run(32'h0000_2000, 1'b0, 44'h12345, 8'h43, 0, 64'd0, 0, 0);

        // Store setting A and D; mem_req_ready stalls 4 cycles, resp_ready stalls 5
        pin_set(1'b0, 1'b0, 1, 1'b1, 44'h80001, 8'hC7);
        run(32'h8000_1234, 1'b1, 44'h80001, 8'h07, 0, 64'h0000_0000_2000_0407, 4, 5);

        // PTE changed underneath: V cleared, then PPN moved
        pin_set(1'b1, 1'b0, 1, 1'b0, 44'h0, 8'h0);
        run(32'h8000_1234, 1'b1, 44'h80001, 8'h07, 0, 64'h0000_0000_2000_0406, 0, 0);
        pin_set(1'b1, 1'b0, 1, 1'b0, 44'h0, 8'h0);
        run(32'h8000_1234, 1'b1, 44'h80001, 8'h07, 0, 64'h0000_0000_2000_0807, 0, 0);

        // Retry exhaustion, and two NACKs followed by success
        pin_set(1'b1, 1'b0, 3, 1'b1, 44'h80001, 8'h07);
        run(32'h8000_1234, 1'b1, 44'h80001, 8'h07, 3, 64'h0000_0000_2000_0407, 0, 0);
        pin_set(1'b0, 1'b0, 3, 1'b1, 44'h80001, 8'hC7);
        run(32'h8000_1234, 1'b1, 44'h80001, 8'h07, 2, 64'h0000_0000_2000_0407, 1, 2);

        // Early faults, including fault winning over skip
        run(32'h0000_1008, 1'b0, 44'h00abc, 8'h06, 0, 64'd0, 0, 0);
        run(32'h0000_1010, 1'b0, 44'h00abc, 8'h0D, 0, 64'd0, 0, 1);
        run(32'h0000_1018, 1'b1, 44'h00abc, 8'h01, 0, 64'd0, 0, 0);
        run(32'h0000_1020, 1'b1, 44'h00abc, 8'hC2, 0, 64'd0, 0, 0);

        // Store to dirty PTE skips; store with A set but D clear goes to memory
        run(32'h0000_3000, 1'b1, 44'h00777, 8'hC3, 0, 64'd0, 0, 0);
        run(32'h0000_3008, 1'b1, 44'h00777, 8'h4B, 0, 64'h0000_0000_001D_DC7B, 0, 0);
        // Execute-only load, old PTE already dirty with G/U set
        run(32'h0000_400C, 1'b0, 44'h00321, 8'h09, 0, 64'h0000_0000_000C_84B9, 2, 0);

        // Asynchronous reset while waiting on memory; the late response is dropped
        set_model(32'h8000_1234, 1'b1, 44'h80001, 8'h07, 0, 64'h0000_0000_2000_0407);
        drive_req(32'h8000_1234, 1'b1, 44'h80001, 8'h07);
        step();
        io_mem_req_ready = 1'b1;
        step();
        io_mem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data = 64'h0000_0000_2000_0407;
        step();
        rst_n = 1'b1;
        step();
        io_mem_resp_valid = 1'b0;
        step();
        step();

        // Normal operation after the reset
        pin_set(1'b0, 1'b0, 1, 1'b1, 44'h80001, 8'hC7);
        run(32'h8000_1234, 1'b1, 44'h80001, 8'h07, 0, 64'h0000_0000_2000_0407, 0, 0);
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
